copro_responder: RTL and testbench

- Coprocessor-side responder for the core's instruction offload port. The issue stage offloads an instruction with its operands and a transaction id; this block answers the issue handshake with accept/writeback flags.
- It waits for commit or kill from the core, executes a small custom opcode set, and returns one result carrying the transaction id, destination and exception fields to the core's writeback port.
- One instruction in flight.

---
 rtl/copro_responder.sv | 174 +++++++++++++++++
 tb/tb_copro_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copro_responder.sv
// Coprocessor offload responder: accepts one custom instruction at a time, waits for
// commit/kill, executes it and returns a single result. Optional: COPRO_SPECULATIVE_EXEC_EN.
module copro_responder #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int MUL_LATENCY   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [TRANS_ID_BITS-1:0] issue_id_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0] commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [TRANS_ID_BITS-1:0] result_id_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic                     result_exc_o,
  output logic [5:0]               result_exccode_o
);

  localparam logic [6:0] OPC_CUSTOM = 7'b1111011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_MUL = 3'b001;
  localparam logic [2:0] F3_NOP = 3'b010;
  localparam logic [2:0] F3_EXC = 3'b111;

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESP} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [31:0]              instr_q;
  logic [XLEN-1:0]          rs1_q, rs2_q, data_q, exec_result;
  logic                     wb_q;
  logic                     capture;

  logic [2:0] dec_f3, f3_q;
  logic       dec_known, dec_arith, take, commit_hit, in_resp;

  assign dec_f3    = issue_instr_i[14:12];
  assign f3_q      = instr_q[14:12];
  assign dec_known = (issue_instr_i[6:0] == OPC_CUSTOM) &&
                     (dec_f3 == F3_ADD || dec_f3 == F3_MUL || dec_f3 == F3_NOP || dec_f3 == F3_EXC);
  assign dec_arith = (issue_instr_i[6:0] == OPC_CUSTOM) && (dec_f3 == F3_ADD || dec_f3 == F3_MUL);

  assign issue_ready_o     = (state_q == IDLE) && (issue_rs_valid_i == 2'b11);
  assign issue_accept_o    = issue_ready_o && dec_known;
  assign issue_writeback_o = issue_ready_o && dec_arith && (issue_instr_i[11:7] != 5'd0);

  assign take       = issue_valid_i && issue_accept_o;
  assign commit_hit = commit_valid_i && (commit_id_i == id_q);

  always_comb begin
    exec_result = '0;
    case (f3_q)
      F3_ADD:  exec_result = rs1_q + rs2_q;
      F3_MUL:  exec_result = rs1_q * rs2_q;
      F3_EXC:  exec_result = XLEN'(instr_q);
      default: exec_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = WAIT_COMMIT;
`ifdef COPRO_SPECULATIVE_EXEC_EN
          cnt_d = (dec_f3 == F3_MUL) ? MUL_CNT : '0;
`endif
        end
      end
      WAIT_COMMIT: begin
`ifdef COPRO_SPECULATIVE_EXEC_EN
        // Execution already running: the counter keeps draining while we wait.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (commit_hit) begin
          if (commit_kill_i || f3_q == F3_NOP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q <= CNT_ONE) begin
            capture = 1'b1;
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = EXEC;
          end
        end
`else
        if (commit_hit) begin
          if (commit_kill_i || f3_q == F3_NOP) begin
            state_d = IDLE;
          end else if (f3_q != F3_MUL || MUL_CNT == '0) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = EXEC;
            cnt_d   = MUL_CNT;
          end
        end
`endif
      end
      EXEC: begin
        if (commit_hit && commit_kill_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          capture = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wb_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        id_q    <= issue_id_i;
        instr_q <= issue_instr_i;
        rs1_q   <= issue_rs1_i;
        rs2_q   <= issue_rs2_i;
        wb_q    <= issue_writeback_o;
      end
      if (capture) data_q <= exec_result;
    end
  end

  // Result fields are forced to zero outside RESP so the writeback port is quiet when idle.
  assign in_resp          = (state_q == RESP);
  assign result_valid_o   = in_resp;
  assign result_id_o      = in_resp ? id_q : '0;
  assign result_data_o    = in_resp ? data_q : '0;
  assign result_rd_o      = in_resp ? instr_q[11:7] : 5'd0;
  assign result_we_o      = in_resp && wb_q;
  assign result_exc_o     = in_resp && (f3_q == F3_EXC);
  assign result_exccode_o = (in_resp && f3_q == F3_EXC) ? 6'd2 : 6'd0;

endmodule

// File: tb/tb_copro_responder.sv
// Randomized self-checking bench for copro_responder against a transaction-level model;
// timing expectations follow COPRO_SPECULATIVE_EXEC_EN when it is defined.
module tb_copro_responder;

  localparam int XLEN    = 64;
  localparam int TIDB    = 3;
  localparam int MUL_LAT = 4;
  localparam logic [6:0] OPC = 7'b1111011;
`ifdef COPRO_SPECULATIVE_EXEC_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_ready, issue_accept, issue_writeback;
  logic [31:0]     issue_instr;
  logic [TIDB-1:0] issue_id;
  logic [XLEN-1:0] issue_rs1, issue_rs2;
  logic [1:0]      issue_rs_valid;
  logic            commit_valid, commit_kill;
  logic [TIDB-1:0] commit_id;
  logic            result_valid, result_ready, result_we, result_exc;
  logic [TIDB-1:0] result_id;
  logic [XLEN-1:0] result_data;
  logic [4:0]      result_rd;
  logic [5:0]      result_exccode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  copro_responder #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB), .MUL_LATENCY(MUL_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_rs_valid_i(issue_rs_valid), .issue_accept_o(issue_accept),
    .issue_writeback_o(issue_writeback),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we),
    .result_exc_o(result_exc), .result_exccode_o(result_exccode)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: which instructions the coprocessor recognises.
  function automatic bit refKnown(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return (instr[6:0] == OPC) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd7);
  endfunction

  function automatic logic [63:0] refResult(input logic [31:0] instr, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] wide;
    wide = '0;
    case (instr[14:12])
      3'd0: wide = {64'd0, a} + {64'd0, b};
      3'd1: wide = {64'd0, a} * {64'd0, b};
      3'd7: wide = {96'd0, instr};
      default: wide = '0;
    endcase
    return wide[63:0];
  endfunction

  task automatic expectQuiet(input string tag, input int n);
    repeat (n) begin
      checkOutput({tag, "_no_result"}, result_valid, 1'b0);
      tick();
    end
    checkOutput({tag, "_back_idle"}, issue_ready, 1'b1);
  endtask

  // One complete offload transaction: issue, optional stray commits, commit/kill, drain.
  task automatic applyStimulus(input logic [31:0] instr, input logic [TIDB-1:0] id,
                               input logic [63:0] a, input logic [63:0] b, input int commitDelay,
                               input bit kill, input bit stray, input int readyDelay);
    bit acc, wb, isMul, noRes;
    int h, c, v, lat;
    logic [63:0] expData;
    acc   = refKnown(instr);
    isMul = instr[14:12] == 3'd1;
    wb    = acc && (instr[14:12] == 3'd0 || isMul) && (instr[11:7] != 5'd0);
    issue_valid = 1'b1; issue_instr = instr; issue_id = id;
    issue_rs1 = a; issue_rs2 = b; issue_rs_valid = 2'b11;
    commit_valid = stray; commit_id = id; commit_kill = 1'b0;
    #1;
    checkOutput("issue_ready", issue_ready, 1'b1);
    checkOutput("issue_accept", issue_accept, acc);
    checkOutput("issue_writeback", issue_writeback, wb);
    h = cyc;
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0; issue_instr = $urandom;
    if (!acc) begin
      expectQuiet("reject", MUL_LAT + 2);
      return;
    end
    for (int i = 1; i < commitDelay; i++) begin
      if (stray && i == 1) begin
        commit_valid = 1'b1; commit_id = id ^ TIDB'($urandom_range(1, 7)); commit_kill = $urandom;
      end
      #1;
      checkOutput("wait_no_result", result_valid, 1'b0);
      checkOutput("wait_not_ready", issue_ready, 1'b0);
      tick();
      commit_valid = 1'b0;
    end
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    c = cyc;
    #1;
    checkOutput("commit_cycle_quiet", result_valid, 1'b0);
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
    noRes = kill || (instr[14:12] == 3'd2);
    if (noRes) begin
      expectQuiet(kill ? "kill" : "cnop", MUL_LAT + 2);
      return;
    end
    lat = isMul ? MUL_LAT : 1;
    v = c + lat;
    if (SPEC) v = (h + lat > c + 1) ? h + lat : c + 1;
    while (cyc < v) begin
      checkOutput("early_result", result_valid, 1'b0);
      tick();
    end
    expData = refResult(instr, a, b);
    for (int k = 0; k <= readyDelay; k++) begin
      result_ready = (k == readyDelay);
      if (stray && k == 0) begin
        commit_valid = 1'b1; commit_id = id ^ TIDB'($urandom_range(1, 7)); commit_kill = 1'b1;
      end
      #1;
      checkOutput("resp_valid", result_valid, 1'b1);
      checkOutput("resp_id", result_id, id);
      checkOutput("resp_data", result_data, expData);
      checkOutput("resp_rd", result_rd, instr[11:7]);
      checkOutput("resp_we", result_we, wb);
      checkOutput("resp_exc", result_exc, instr[14:12] == 3'd7);
      checkOutput("resp_exccode", result_exccode, (instr[14:12] == 3'd7) ? 6'd2 : 6'd0);
      checkOutput("resp_not_ready", issue_ready, 1'b0);
      tick();
      commit_valid = 1'b0; commit_kill = 1'b0;
    end
    result_ready = 1'b0;
    checkOutput("post_resp_quiet", result_valid, 1'b0);
    checkOutput("post_resp_ready", issue_ready, 1'b1);
  endtask

  function automatic logic [31:0] mkInstr(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, OPC};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    rst = 1'b1; issue_valid = 1'b0; issue_instr = '0; issue_id = '0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rs_valid = 2'b00;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b0;
    tick(); tick();
    checkOutput("reset_ready", issue_ready, 1'b0);
    checkOutput("reset_accept", issue_accept, 1'b0);
    checkOutput("reset_valid", result_valid, 1'b0);
    checkOutput("reset_data", result_data, '0);
    checkOutput("reset_exc", {result_exc, result_exccode}, '0);
    rst = 1'b0;
    issue_rs_valid = 2'b11;
    #1;
    checkOutput("idle_ready", issue_ready, 1'b1);

    $display("[TB] directed transactions");
    applyStimulus(mkInstr(3'd0, 5'd10), 3'd3, 64'd5, 64'd7, 1, 1'b0, 1'b0, 0);
    applyStimulus(mkInstr(3'd1, 5'd4), 3'd1, 64'h1_0000_0000, 64'h2_0000_0000, 2, 1'b0, 1'b0, 3);
    applyStimulus({17'd0, 3'd0, 5'd6, 7'b0110011}, 3'd4, 64'd1, 64'd2, 1, 1'b0, 1'b0, 0);
    applyStimulus(mkInstr(3'd0, 5'd7), 3'd2, 64'd9, 64'd9, 3, 1'b1, 1'b1, 0);
    applyStimulus(mkInstr(3'd0, 5'd0), 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1, 1'b0, 1'b0, 1);

    // Operands not both valid: the responder must not offer a handshake.
    issue_valid = 1'b1; issue_instr = mkInstr(3'd7, 5'd3); issue_rs_valid = 2'b01;
    #1;
    checkOutput("rs_invalid_ready", issue_ready, 1'b0);
    checkOutput("rs_invalid_accept", issue_accept, 1'b0);
    checkOutput("rs_invalid_wb", issue_writeback, 1'b0);
    tick();
    issue_valid = 1'b0;
    applyStimulus(mkInstr(3'd7, 5'd3), 3'd5, 64'd1, 64'd2, 2, 1'b0, 1'b0, 1);
    applyStimulus(mkInstr(3'd2, 5'd8), 3'd0, 64'd1, 64'd2, 1, 1'b0, 1'b0, 0);

    // Reset in the middle of a multiply.
    issue_valid = 1'b1; issue_instr = mkInstr(3'd1, 5'd9); issue_id = 3'd7;
    issue_rs1 = 64'd3; issue_rs2 = 64'd5; issue_rs_valid = 2'b11;
    tick();
    issue_valid = 1'b0; commit_valid = 1'b1; commit_id = 3'd7; commit_kill = 1'b0;
    tick();
    commit_valid = 1'b0;
    tick();
    rst = 1'b1; issue_rs_valid = 2'b00;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", issue_ready, 1'b0);
    checkOutput("midrst_valid", result_valid, 1'b0);
    checkOutput("midrst_fields", {result_id, result_rd, result_we, result_exc, result_exccode}, '0);
    checkOutput("midrst_data", result_data, '0);
    issue_rs_valid = 2'b11;
    #1;
    checkOutput("midrst_ready_again", issue_ready, 1'b1);
    expectQuiet("midrst", MUL_LAT + 2);

    applyStimulus(mkInstr(3'd1, 5'd12), 3'd2, 64'd123456789, 64'd987654321, 10, 1'b0, 1'b0, 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        instr[6:0] = OPC;
        if ($urandom_range(0, 9) < 8) begin
          case ($urandom_range(0, 3))
            0: instr[14:12] = 3'd0;
            1: instr[14:12] = 3'd1;
            2: instr[14:12] = 3'd2;
            default: instr[14:12] = 3'd7;
          endcase
        end
      end
      if ($urandom_range(0, 7) == 0) instr[11:7] = 5'd0;
      applyStimulus(instr, TIDB'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(1, 8), $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
